// File: rtl/bg_pkg.sv
// Shared constants and types for the background frame-draw path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bg_pkg;

  localparam int H_RES    = 320;
  localparam int V_RES    = 240;
  localparam int COORD_W  = 9;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] GREEN = 3'b010;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  // Last coordinate on each axis, sized to the coordinate bus.
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

  typedef logic [COORD_W-1:0] coord_t;

  // Coordinate pair carried alongside an outstanding generator query.
  typedef struct packed {
    coord_t x;
    coord_t y;
  } pix_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/pixel_delay_line.sv
// Shift register carrying {valid, data} so a query's coordinates line up with its colour.
// Latency: DEPTH cycles from in_vld/in_dat to out_vld/out_dat.
// Backpressure: none; advances every cycle, reset clears every valid bit.
module pixel_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 18
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];

  // Shift one stage per cycle; reset discards everything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld;
      dat_q[0] <= in_dat;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/background_scanner.sv
// Raster-sweeps the frame through the background generator and streams aligned VGA writes.
// Latency: plot for a query issued in cycle T appears in cycle T+BG_LATENCY+1; done follows the last plot.
// Backpressure: none; one pixel per cycle, start ignored unless IDLE. SKIP_BLACK_EN suppresses black plots.
module background_scanner import bg_pkg::*; #(
  parameter int BG_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [COORD_W-1:0]  bg_x,
  output logic [COORD_W-1:0]  bg_y,
  input  logic [COLOUR_W-1:0] bg_colour,
  output logic [COORD_W-1:0]  vga_x,
  output logic [COORD_W-1:0]  vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  // Drain runs BG_LATENCY+1 cycles: counter walks 0..BG_LATENCY.
  localparam int                  DRAIN_W    = $clog2(BG_LATENCY + 2);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(BG_LATENCY);

  scan_state_t        state, state_nxt;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic               q_vld;
  pix_t               q_pix;
  logic               dl_vld;
  pix_t               dl_pix;

  // State, query counters and drain counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bg_x      <= '0;
      bg_y      <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      bg_x      <= x_nxt;
      bg_y      <= y_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // Next-state, raster stepping and status outputs.
  always_comb begin
    state_nxt = state;
    x_nxt     = bg_x;
    y_nxt     = bg_y;
    drain_nxt = drain_cnt;
    q_vld     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = SCAN;
          x_nxt     = '0;
          y_nxt     = '0;
        end
      end
      SCAN: begin
        q_vld = 1'b1;
        if (bg_x == X_LAST) begin
          if (bg_y == Y_LAST) begin
            // Last query issued: coordinates hold while the pipe empties.
            state_nxt = DRAIN;
            drain_nxt = '0;
          end else begin
            x_nxt = '0;
            y_nxt = bg_y + COORD_W'(1);
          end
        end else begin
          x_nxt = bg_x + COORD_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = DONE;
        end else begin
          drain_nxt = drain_cnt + DRAIN_W'(1);
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign q_pix.x = bg_x;
  assign q_pix.y = bg_y;

  pixel_delay_line #(
    .DEPTH (BG_LATENCY),
    .W     ($bits(pix_t))
  ) u_delay (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (q_vld),
    .in_dat  (q_pix),
    .out_vld (dl_vld),
    .out_dat (dl_pix)
  );

  // Write stage: pair the delayed coordinates with the colour arriving this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
`ifdef SKIP_BLACK_EN
      vga_plot <= dl_vld && (bg_colour != BLACK);
`else
      vga_plot <= dl_vld;
`endif
      if (dl_vld) begin
        vga_x      <= dl_pix.x;
        vga_y      <= dl_pix.y;
        vga_colour <= bg_colour;
      end
    end
  end

endmodule

// File: tb/tb_background_scanner.sv
// Scoreboard bench: behavioural background generator, expected-plot queue, per-cycle monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_background_scanner;
  import bg_pkg::*;

  localparam int L = 1;
  localparam int N = H_RES * V_RES;

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic                busy;
  logic                done;
  logic [COORD_W-1:0]  bg_x;
  logic [COORD_W-1:0]  bg_y;
  logic [COLOUR_W-1:0] bg_colour;
  logic [COORD_W-1:0]  vga_x;
  logic [COORD_W-1:0]  vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  always #5 clock = ~clock;

  background_scanner #(.BG_LATENCY(L)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .bg_x       (bg_x),
    .bg_y       (bg_y),
    .bg_colour  (bg_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  // Scene: ground band, a white cloud, and a stripe pattern that includes black.
  function automatic logic [2:0] bg_model(int x, int y);
    if (y >= 232) return GREEN;
    if (y >= 170 && y <= 190 && x >= 40 && x <= 140) return WHITE;
    return 3'((x * 7 + y * 3) >> 4);
  endfunction

  // Behavioural generator with L cycles of latency.
  logic [2:0] gen_pipe [L];
  always @(posedge clock) begin
    gen_pipe[0] <= bg_model(int'(bg_x), int'(bg_y));
    for (int k = 1; k < L; k++) gen_pipe[k] <= gen_pipe[k-1];
  end
  assign bg_colour = gen_pipe[L-1];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } exp_t;

  exp_t plot_q[$];
  int   done_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   busy_lo, busy_hi, scan_s, idle_from, rst_chk;
  int   plots_exp, plots_seen;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model of a reset edge: nothing outstanding, ready to start now.
  task automatic model_reset();
    plot_q.delete();
    done_q.delete();
    busy_lo   = 1;
    busy_hi   = 0;
    scan_s    = -1;
    rst_chk   = cyc;
    idle_from = cyc;
  endtask

  // Pulse start in the current cycle; if the model says IDLE, queue the whole frame.
  task automatic start_frame();
    int s;
    int c;
    s = cyc;
    start = 1'b1;
    if (s >= idle_from) begin
      plots_exp  = 0;
      plots_seen = 0;
      for (int i = 0; i < N; i++) begin
        c = int'(bg_model(i % H_RES, i / H_RES));
`ifdef SKIP_BLACK_EN
        if (c != 0) begin
          plot_q.push_back('{i % H_RES, i / H_RES, c, s + 1 + i + L + 1});
          plots_exp++;
        end
`else
        plot_q.push_back('{i % H_RES, i / H_RES, c, s + 1 + i + L + 1});
        plots_exp++;
`endif
      end
      busy_lo   = s + 1;
      busy_hi   = s + N + L + 2;
      done_q.push_back(busy_hi);
      scan_s    = s;
      idle_from = busy_hi + 1;
    end
    tick();
    start = 1'b0;
  endtask

  // Monitor: compares every cycle against the expectations the stimulus queued.
  initial begin
    int   i, ex, ey;
    bit   exp_busy, exp_done, exp_plot;
    exp_t e;
    forever begin
      @(negedge clock);
      if (cyc == rst_chk) begin
        check("rst_bg_x", int'(bg_x), 0);
        check("rst_bg_y", int'(bg_y), 0);
        check("rst_vga_x", int'(vga_x), 0);
        check("rst_vga_y", int'(vga_y), 0);
        check("rst_vga_colour", int'(vga_colour), 0);
        check("rst_vga_plot", int'(vga_plot), 0);
        check("rst_done", int'(done), 0);
      end
      exp_busy = (cyc >= busy_lo && cyc <= busy_hi);
      check("busy", int'(busy), int'(exp_busy));
      exp_done = (done_q.size() > 0 && done_q[0] == cyc);
      check("done", int'(done), int'(exp_done));
      if (exp_done) void'(done_q.pop_front());
      if (scan_s >= 0 && cyc > scan_s && cyc <= busy_hi) begin
        i = cyc - scan_s - 1;
        if (i < N) begin
          ex = i % H_RES;
          ey = i / H_RES;
        end else begin
          ex = H_RES - 1;
          ey = V_RES - 1;
        end
        check("bg_x", int'(bg_x), ex);
        check("bg_y", int'(bg_y), ey);
      end
      exp_plot = (plot_q.size() > 0 && plot_q[0].t == cyc);
      check("vga_plot", int'(vga_plot), int'(exp_plot));
      if (exp_plot) begin
        e = plot_q.pop_front();
        if (vga_plot) begin
          plots_seen++;
          check("vga_x", int'(vga_x), e.x);
          check("vga_y", int'(vga_y), e.y);
          check("vga_colour", int'(vga_colour), e.c);
        end
      end else if (vga_plot) begin
        plots_seen++;
      end
    end
  end

  // Stimulus: aborted frame with reset at query (100,50), then a full frame with stray starts.
  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    busy_lo    = 1;
    busy_hi    = 0;
    scan_s     = -1;
    rst_chk    = -1;
    idle_from  = 0;
    plots_exp  = 0;
    plots_seen = 0;
    repeat (3) tick();
    reset = 1'b0;
    model_reset();

    start_frame();
    while (cyc < scan_s + 1 + 50 * H_RES + 100) begin
      start = ($urandom_range(0, 63) == 0);
      tick();
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    repeat ($urandom_range(0, 3)) tick();

    start_frame();
    while (cyc <= busy_hi + 5) begin
      start = (cyc < idle_from) &&
              (($urandom_range(0, 31) == 0) || cyc == busy_hi || cyc == busy_hi - 1);
      tick();
    end
    start = 1'b0;
    tick();

    check("plot_count", plots_seen, plots_exp);
    check("plot_q_left", plot_q.size(), 0);
    check("done_q_left", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
